pc_sequencer: RTL and testbench

Program-counter sequencer for the core's fetch stage. Holds the PC and advances it sequentially. Drives the branch-enable input of the branch target LUT and applies the returned signed relative offset when a branch is taken. Manages start/halt, pipeline stall and a post-branch flush window, and feeds the fetch address to instruction memory.

---
 rtl/pc_sequencer_if.sv | 42 ++++
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bus between the fetch-stage control and the PC sequencer.
// The sequencer connects through the slave modport and the control side through master.
// With PC_SEQ_CALL_RET_EN defined the bus also carries call, ret and ret_addr.
interface pc_sequencer_if #(
    parameter int PW = 12,
    parameter int OW = 12
);
    logic          start;
    logic          stall;
    logic          branch_taken;
    logic [OW-1:0] offset;
    logic          halt_req;
    logic          lut_en;
    logic [PW-1:0] pc;
    logic          fetch_valid;
    logic          flush;
    logic          done;
    logic [7:0]    branch_count;
`ifdef PC_SEQ_CALL_RET_EN
    logic          call;
    logic          ret;
    logic [PW-1:0] ret_addr;

    modport master (
        output start, stall, branch_taken, offset, halt_req, call, ret,
        input  lut_en, pc, fetch_valid, flush, done, branch_count, ret_addr
    );
    modport slave (
        input  start, stall, branch_taken, offset, halt_req, call, ret,
        output lut_en, pc, fetch_valid, flush, done, branch_count, ret_addr
    );
`else
    modport master (
        output start, stall, branch_taken, offset, halt_req,
        input  lut_en, pc, fetch_valid, flush, done, branch_count
    );
    modport slave (
        input  start, stall, branch_taken, offset, halt_req,
        output lut_en, pc, fetch_valid, flush, done, branch_count
    );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// It steps the PC, applies signed relative branch offsets from the branch target LUT,
// inserts FLUSH_CYC bubble cycles after every redirect and handles start, halt and stall.
// Optional feature macro: PC_SEQ_CALL_RET_EN adds a one-level call/return.
module pc_sequencer #(
    parameter int PW        = 12,
    parameter int OW        = 12,
    parameter int FLUSH_CYC = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } state_t;

    // The counter starts one below the bubble count so it reaches zero in the last bubble.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

    state_t        state_reg, state_next;
    logic [PW-1:0] pc_reg, pc_next;
    logic [2:0]    cnt_reg, cnt_next;
    logic [7:0]    bc_reg, bc_next;
    logic          lut_en_c;
    logic [PW-1:0] offset_ext;
    logic          take_branch;
`ifdef PC_SEQ_CALL_RET_EN
    logic [PW-1:0] ret_reg, ret_next;
`endif

    // Sign-extend the LUT offset to PC width; the add below then wraps modulo 2^PW.
    assign offset_ext = PW'($signed(bus.offset));

`ifdef PC_SEQ_CALL_RET_EN
    assign take_branch = bus.branch_taken | bus.call;
`else
    assign take_branch = bus.branch_taken;
`endif

    // State register and datapath registers; reset overrides every other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            cnt_reg   <= '0;
            bc_reg    <= '0;
`ifdef PC_SEQ_CALL_RET_EN
            ret_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
            bc_reg    <= bc_next;
`ifdef PC_SEQ_CALL_RET_EN
            ret_reg   <= ret_next;
`endif
        end
    end

    // Next-state logic, PC update and the combinational LUT enable.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        bc_next    = bc_reg;
        lut_en_c   = 1'b0;
`ifdef PC_SEQ_CALL_RET_EN
        ret_next   = ret_reg;
`endif
        case (state_reg)
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                    bc_next    = '0;
                end
            end
            RUN: begin
                if (bus.stall) begin
                    state_next = RUN;
                end else if (bus.halt_req) begin
                    state_next = HALTED;
                end else if (take_branch
`ifdef PC_SEQ_CALL_RET_EN
                             && (bus.call || !bus.ret)
`endif
                            ) begin
                    lut_en_c   = 1'b1;
                    pc_next    = pc_reg + offset_ext;
                    state_next = FLUSH;
                    cnt_next   = FLUSH_INIT;
                    bc_next    = (bc_reg == 8'hFF) ? bc_reg : bc_reg + 8'd1;
`ifdef PC_SEQ_CALL_RET_EN
                    if (bus.call) begin
                        ret_next = pc_reg + PW'(1);
                    end
`endif
`ifdef PC_SEQ_CALL_RET_EN
                end else if (bus.ret) begin
                    pc_next    = ret_reg;
                    state_next = FLUSH;
                    cnt_next   = FLUSH_INIT;
`endif
                end else begin
                    pc_next = pc_reg + PW'(1);
                end
            end
            FLUSH: begin
                if (bus.stall) begin
                    state_next = FLUSH;
                end else if (bus.halt_req) begin
                    state_next = HALTED;
                end else if (cnt_reg == 3'd0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.lut_en       = lut_en_c;
    assign bus.pc           = pc_reg;
    assign bus.fetch_valid  = (state_reg == RUN);
    assign bus.flush        = (state_reg == FLUSH);
    assign bus.done         = (state_reg == HALTED);
    assign bus.branch_count = bc_reg;
`ifdef PC_SEQ_CALL_RET_EN
    assign bus.ret_addr     = ret_reg;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: one instance with FLUSH_CYC=1 driven from a vector table,
// a second with FLUSH_CYC=3 for multi-cycle flush, reset-in-flush and self-loop sequences.
module tb_pc_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    pc_sequencer_if #(.PW(12), .OW(12)) if1();
    pc_sequencer_if #(.PW(12), .OW(12)) if3();

    pc_sequencer #(.PW(12), .OW(12), .FLUSH_CYC(1)) dut1 (.Clk(clk), .Reset(rst1), .bus(if1.slave));
    pc_sequencer #(.PW(12), .OW(12), .FLUSH_CYC(3)) dut3 (.Clk(clk), .Reset(rst3), .bus(if3.slave));

    typedef struct {
        logic        rst, start, stall, br, halt;
        logic [11:0] off;
        logic        e_lut;
        logic [11:0] e_pc;
        logic        e_fv, e_fl, e_done;
        logic [7:0]  e_bc;
    } vec_t;

    int checks = 0;
    int failures = 0;
    vec_t tab1[$];
    vec_t tab3[$];

    function automatic vec_t mk(int rst, int st, int stl, int br, int hlt, int off,
                                int lut, int pc, int fv, int fl, int dn, int bc);
        vec_t v;
        v.rst = rst[0]; v.start = st[0]; v.stall = stl[0]; v.br = br[0]; v.halt = hlt[0];
        v.off = off[11:0]; v.e_lut = lut[0]; v.e_pc = pc[11:0];
        v.e_fv = fv[0]; v.e_fl = fl[0]; v.e_done = dn[0]; v.e_bc = bc[7:0];
        return v;
    endfunction

    // Plain RUN cycle with no events: expect pc, fetch_valid=1.
    function automatic vec_t rn(int pc, int bc);
        return mk(0, 0, 0, 0, 0, 0, 0, pc, 1, 0, 0, bc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic apply(input bit sel, input vec_t v, input string tag);
        logic        lut, fv, fl, dn;
        logic [11:0] pc;
        logic [7:0]  bc;
        @(negedge clk);
        if (sel) begin
            rst3 = v.rst; if3.start = v.start; if3.stall = v.stall;
            if3.branch_taken = v.br; if3.halt_req = v.halt; if3.offset = v.off;
        end else begin
            rst1 = v.rst; if1.start = v.start; if1.stall = v.stall;
            if1.branch_taken = v.br; if1.halt_req = v.halt; if1.offset = v.off;
        end
        #1;
        lut = sel ? if3.lut_en : if1.lut_en;
        chk({tag, " lut_en"}, 32'(lut), 32'(v.e_lut));
        @(posedge clk);
        #1;
        pc = sel ? if3.pc : if1.pc;
        fv = sel ? if3.fetch_valid : if1.fetch_valid;
        fl = sel ? if3.flush : if1.flush;
        dn = sel ? if3.done : if1.done;
        bc = sel ? if3.branch_count : if1.branch_count;
        chk({tag, " pc"}, 32'(pc), 32'(v.e_pc));
        chk({tag, " fetch_valid"}, 32'(fv), 32'(v.e_fv));
        chk({tag, " flush"}, 32'(fl), 32'(v.e_fl));
        chk({tag, " done"}, 32'(dn), 32'(v.e_done));
        chk({tag, " branch_count"}, 32'(bc), 32'(v.e_bc));
        $display("%s: pc=%0d fv=%0b flush=%0b done=%0b bc=%0d lut=%0b",
                 tag, pc, fv, fl, dn, bc, lut);
    endtask

    initial begin
        int bc_exp;
        rst1 = 1'b1; rst3 = 1'b1;
        if1.start = 0; if1.stall = 0; if1.branch_taken = 0; if1.halt_req = 0; if1.offset = '0;
        if3.start = 0; if3.stall = 0; if3.branch_taken = 0; if3.halt_req = 0; if3.offset = '0;
`ifdef PC_SEQ_CALL_RET_EN
        if1.call = 0; if1.ret = 0; if3.call = 0; if3.ret = 0;
`endif

        // ---- FLUSH_CYC=1 table ----
        tab1.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0));   // reset
        tab1.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0));
        tab1.push_back(mk(0, 0, 0, 1, 1, 5,      0, 0, 0, 0, 0, 0));   // IDLE ignores inputs
        tab1.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0, 1, 0, 0, 0));   // start
        for (int i = 1; i <= 3; i++) tab1.push_back(rn(i, 0));
        tab1.push_back(mk(0, 1, 0, 0, 0, 0,      0, 4, 1, 0, 0, 0));   // start ignored in RUN
        for (int i = 5; i <= 7; i++) tab1.push_back(rn(i, 0));
        tab1.push_back(mk(0, 0, 1, 1, 0, 2,      0, 7, 1, 0, 0, 0));   // stall beats branch
        tab1.push_back(mk(0, 0, 1, 1, 0, 2,      0, 7, 1, 0, 0, 0));
        tab1.push_back(mk(0, 0, 0, 1, 0, 2,      1, 9, 0, 1, 0, 1));   // branch +2
        tab1.push_back(rn(9, 1));
        tab1.push_back(mk(0, 0, 0, 1, 1, 3,      0, 9, 0, 0, 1, 1));   // halt beats branch
        tab1.push_back(mk(0, 0, 1, 1, 0, 3,      0, 9, 0, 0, 1, 1));   // HALTED ignores stall
        tab1.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0, 1, 0, 0, 0));   // restart clears count
        for (int i = 1; i <= 10; i++) tab1.push_back(rn(i, 0));
        tab1.push_back(mk(0, 0, 0, 1, 0, 'hFFB,  1, 5, 0, 1, 0, 1));   // -5 from 10
        tab1.push_back(mk(0, 0, 0, 1, 0, 7,      0, 5, 1, 0, 0, 1));   // branch ignored in FLUSH
        tab1.push_back(rn(6, 1));
        tab1.push_back(mk(0, 0, 0, 1, 0, 'hFF4,  1, 4090, 0, 1, 0, 2)); // 6-12 wraps
        tab1.push_back(rn(4090, 2));
        tab1.push_back(mk(0, 0, 0, 1, 0, 20,     1, 14, 0, 1, 0, 3));  // 4090+20 wraps
        tab1.push_back(rn(14, 3));
        tab1.push_back(mk(0, 0, 0, 1, 0, 'hFF1,  1, 4095, 0, 1, 0, 4)); // 14-15
        tab1.push_back(rn(4095, 4));
        tab1.push_back(rn(0, 4));                                       // increment wraps
        tab1.push_back(rn(1, 4));
        tab1.push_back(mk(0, 0, 0, 1, 0, 3,      1, 4, 0, 1, 0, 5));
        tab1.push_back(mk(0, 0, 1, 0, 0, 0,      0, 4, 0, 1, 0, 5));   // stall holds FLUSH
        tab1.push_back(rn(4, 5));
        tab1.push_back(rn(5, 5));
        tab1.push_back(mk(0, 0, 0, 1, 0, 0,      1, 5, 0, 1, 0, 6));   // self-loop
        tab1.push_back(mk(0, 0, 0, 0, 1, 0,      0, 5, 0, 0, 1, 6));   // halt in FLUSH
        tab1.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0, 1, 0, 0, 0));
        tab1.push_back(mk(0, 0, 0, 1, 0, 0,      1, 0, 0, 1, 0, 1));
        tab1.push_back(rn(0, 1));

        foreach (tab1[i]) apply(1'b0, tab1[i], $sformatf("d1 v%0d", i));

        // Saturation of the branch counter at 255 using self-loop branches.
        bc_exp = 1;
        for (int i = 0; i < 258; i++) begin
            bc_exp = (bc_exp == 255) ? 255 : bc_exp + 1;
            apply(1'b0, mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, bc_exp), $sformatf("sat b%0d", i));
            apply(1'b0, rn(0, bc_exp), $sformatf("sat r%0d", i));
        end

        // ---- FLUSH_CYC=3 sequences ----
        tab3.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0));
        tab3.push_back(mk(1, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0));
        tab3.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0, 1, 0, 0, 0));
        for (int i = 1; i <= 3; i++) tab3.push_back(rn(i, 0));
        tab3.push_back(mk(0, 0, 0, 1, 0, 5,      1, 8, 0, 1, 0, 1));   // flush cycle 1
        tab3.push_back(mk(0, 0, 0, 0, 0, 0,      0, 8, 0, 1, 0, 1));   // flush cycle 2
        tab3.push_back(mk(0, 0, 0, 0, 0, 0,      0, 8, 0, 1, 0, 1));   // flush cycle 3
        tab3.push_back(rn(8, 1));                                       // first fetch at target
        tab3.push_back(rn(9, 1));
        tab3.push_back(mk(0, 0, 0, 1, 0, 3,      1, 12, 0, 1, 0, 2));
        tab3.push_back(mk(0, 0, 0, 0, 0, 0,      0, 12, 0, 1, 0, 2));  // 2nd flush cycle
        tab3.push_back(mk(1, 0, 0, 1, 0, 3,      0, 0, 0, 0, 0, 0));   // reset mid-flush
        tab3.push_back(mk(0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0));   // stays IDLE
        tab3.push_back(mk(0, 1, 0, 0, 0, 0,      0, 0, 1, 0, 0, 0));
        for (int i = 1; i <= 12; i++) tab3.push_back(rn(i, 0));
        tab3.push_back(mk(0, 0, 0, 1, 0, 0,      1, 12, 0, 1, 0, 1));  // offset 0 at pc 12
        tab3.push_back(mk(0, 0, 0, 0, 0, 0,      0, 12, 0, 1, 0, 1));
        tab3.push_back(mk(0, 0, 0, 0, 0, 0,      0, 12, 0, 1, 0, 1));
        tab3.push_back(rn(12, 1));
        tab3.push_back(rn(13, 1));

        foreach (tab3[i]) apply(1'b1, tab3[i], $sformatf("d3 v%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
